dp_ram_be: RTL and testbench
============================

Name: dp_ram_be

Overview:
Parametrised simple dual-port block RAM: one write port (A), one read port (B), single clock. Adds the following to the plain dual-port RAM:
- per-byte write enables
- selectable read latency (1 or 2 cycles)
- read-valid strobe
- defined read/write collision behaviour
- hardware clear sequencer that zeroes the array after reset or on request

Used for weight/feature buffers in the datapath, where consumers need a valid strobe and guaranteed-zero initial contents.

Parameters:
RAM_DEPTH, 16, number of words; any value >= 2, need not be a power of 2.
ADDR_WIDTH, $clog2(RAM_DEPTH), address width.
DATA_WIDTH, 64, word width; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, write-enable granularity; NB = DATA_WIDTH/BYTE_WIDTH.
OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2.
BYPASS, 1, 1: write-first on same-address collision; 0: read-first.
CLEAR_ON_RESET, 1, 1: run the clear sequence on reset release.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
ena  in  1  port A enable.
wea  in  NB  per-byte write enable; bit i covers dia[i*BYTE_WIDTH +: BYTE_WIDTH].
addra  in  ADDR_WIDTH  write address.
dia  in  DATA_WIDTH  write data.
enb  in  1  port B read enable.
addrb  in  ADDR_WIDTH  read address.
clr  in  1  single-cycle soft-clear request.
dob  out  DATA_WIDTH  read data.
dob_valid  out  1  one-cycle strobe: dob holds data of an accepted read.
init_busy  out  1  clear sequence in progress; both ports are blocked.

Behaviour:
- Array has exactly RAM_DEPTH words. Array contents are not reset; they are zeroed only by the clear sequencer.
- Reset (rst=0, asynchronous):
  - dob=0, dob_valid=0, all pipeline registers 0, clear counter 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE; init_busy follows state.
  - Reset asserted mid-clear restarts the clear from address 0 after release.
- State machine, two states:
  - IDLE: normal operation. clr=1 -> CLEAR with counter=0, on the next edge.
  - CLEAR: each cycle writes 0 to word[counter] and increments counter. At counter==RAM_DEPTH-1 the write happens and the state returns to IDLE.
  - Clear duration is exactly RAM_DEPTH cycles. init_busy=1 exactly while in CLEAR.
  - clr in CLEAR is ignored (no restart).
- Write (IDLE only): at an edge with ena=1, each byte i with wea[i]=1 takes dia's byte i. Unselected bytes are unchanged. ena=0 or wea=0 means no write.
- Read (IDLE only):
  - enb=1 at edge k -> dob/dob_valid update at edge k (OUT_REG=0) or edge k+1 (OUT_REG=1).
  - dob_valid is high for exactly one cycle per accepted read. Back-to-back reads give a continuous valid stream, one result per cycle.
  - With no read, dob holds its last value and dob_valid=0.
- In CLEAR: ena and enb are ignored, and no new dob_valid is generated. A read accepted before CLEAR entry still completes its pipeline.
- Out-of-range addresses (>= RAM_DEPTH): writes are dropped; reads return 0 with dob_valid=1.
- Collision (ena=1, enb=1, addra==addrb, same edge):
  - BYPASS=1: dob = byte-merge; bytes with wea set come from dia, others are old contents.
  - BYPASS=0: dob = old contents.
  - The array is updated in both cases.
- Read of an address written at an earlier edge always returns the new data.

Decomposition:
- Shared package: NB function/constant; state encoding constants ST_IDLE, ST_CLEAR; byte-merge function (old, new, mask) reused by the bypass path.
- Sub-module: dp_ram_core holds the byte-enable array, the write port and the registered read. It has no reset and maps to block RAM.
- Top level holds the clear FSM, counter, address-range check, collision bypass, optional output register and valid pipeline.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1, RAM_DEPTH=16: init_busy=1 for exactly 16 cycles, then 0; reads of all 16 addresses -> dob=0, dob_valid each one cycle after enb.
2. Write 64'h1122334455667788 to addr 3, then wea=8'h0F with dia=64'hAAAAAAAABBBBBBBB to addr 3; read addr 3 -> 64'h11223344BBBBBBBB.
3. Collision, addr 5 holding 64'h0, write 64'hFF with wea=all ones and read addr 5 in the same cycle: BYPASS=1 -> dob=64'hFF; BYPASS=0 -> dob=0; next read -> 64'hFF in both cases.
4. OUT_REG=1, reads to addrs 0..3 in 4 consecutive cycles: dob_valid high for 4 cycles starting 2 edges after the first enb, data in order.
5. clr pulse with a write on the same cycle, then 3 cycles into the clear: assert clr again and drive ena/enb. Required: writes ignored, no new dob_valid, the repeated clr does not extend init_busy beyond RAM_DEPTH cycles; afterwards all words read 0.
6. rst asserted mid-clear at counter=7, then released: outputs reset immediately (asynchronous), clear restarts, and init_busy lasts RAM_DEPTH cycles after release.

Source files
------------

// File: rtl/dp_ram_be_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_be_pkg
// Description : Shared definitions for the byte-enable dual-port RAM:
//               byte-count helper, clear FSM state encoding and the
//               byte-merge helper used by the collision bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_ram_be_pkg;

    // Widest word the merge helper handles; callers cast in and out.
    localparam int MERGE_W = 4096;

    // Clear sequencer state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Number of write-enable lanes in a word
    function automatic int num_bytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Per-bit merge: bits set in bit_mask come from new_word, the rest from
    // old_word. The caller expands its byte enables into bit_mask.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] bit_mask
    );
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram_be_core.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_core
// Description : Storage array with a byte-enabled write port and a
//               registered read port. No reset, so it maps onto block RAM.
//               The read returns the contents from before a same-edge write.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_core #(
    parameter int RAM_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int NB         = 8
) (
    input  logic                  clk,
    input  logic [NB-1:0]         we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    // Byte-lane writes and registered read in one process (block RAM template)
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                r_mem[waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dp_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_be
// Description : Simple dual-port RAM (write port A, read port B) with
//               byte write enables, 1- or 2-cycle read latency, read-valid
//               strobe, write-first/read-first collision handling and a
//               clear sequencer that zeroes the array after reset or on clr.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_be
    import dp_ram_be_pkg::*;
#(
    parameter int RAM_DEPTH      = 16,
    parameter int ADDR_WIDTH     = $clog2(RAM_DEPTH),
    parameter int DATA_WIDTH     = 64,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          ena,
    input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]  wea,
    input  logic [ADDR_WIDTH-1:0]                         addra,
    input  logic [DATA_WIDTH-1:0]                         dia,
    input  logic                                          enb,
    input  logic [ADDR_WIDTH-1:0]                         addrb,
    input  logic                                          clr,
    output logic [DATA_WIDTH-1:0]                         dob,
    output logic                                          dob_valid,
    output logic                                          init_busy
);

    localparam int                NB          = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE   = ADDR_WIDTH'(1);
    localparam logic [0:0] c_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_busy;
    logic                  w_idle;

    logic                  w_a_in_range;
    logic                  w_b_in_range;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_wea_bits;

    logic [NB-1:0]         w_core_we;
    logic [ADDR_WIDTH-1:0] w_core_waddr;
    logic [DATA_WIDTH-1:0] w_core_wdata;
    logic                  w_core_re;
    logic [DATA_WIDTH-1:0] w_core_rdata;

    logic                  r_v1;
    logic                  r_has_data;
    logic [DATA_WIDTH-1:0] r_byp_mask;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic [DATA_WIDTH-1:0] w_stage1_data;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------

    // State register; reset lands in CLEAR so the array is zeroed on release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clr starts a sweep, the last word ends it; clr mid-sweep is ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clr) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_cnt == c_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State decode: ports are blocked for the whole sweep
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_CLEAR: w_busy = 1'b1;
            default:  w_busy = 1'b0;
        endcase
    end

    assign w_idle    = ~w_busy;
    assign init_busy = w_busy;

    // Sweep address; held at 0 outside CLEAR so every sweep starts at word 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_cnt <= '0;
        end else if (w_busy && (r_clr_cnt != c_LAST)) begin
            r_clr_cnt <= r_clr_cnt + c_ONE;
        end else begin
            r_clr_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Port qualification and array access
    // ------------------------------------------------------------------

    assign w_a_in_range = ({1'b0, addra} < c_DEPTH);
    assign w_b_in_range = ({1'b0, addrb} < c_DEPTH);
    assign w_wr_acc     = w_idle & ena & w_a_in_range;
    assign w_rd_acc     = w_idle & enb;
    assign w_collide    = (BYPASS != 0) & w_wr_acc & w_rd_acc & w_b_in_range & (addra == addrb);

    for (genvar b = 0; b < NB; b++) begin : g_bitmask
        assign w_wea_bits[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wea[b]}};
    end

    // The sweep owns the write port while busy
    assign w_core_we    = w_busy ? {NB{1'b1}} : (w_wr_acc ? wea : '0);
    assign w_core_waddr = w_busy ? r_clr_cnt : addra;
    assign w_core_wdata = w_busy ? '0 : dia;
    assign w_core_re    = w_rd_acc & w_b_in_range;

    dp_ram_core #(
        .RAM_DEPTH  (RAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NB         (NB)
    ) u_core (
        .clk   (clk),
        .we    (w_core_we),
        .waddr (w_core_waddr),
        .wdata (w_core_wdata),
        .re    (w_core_re),
        .raddr (addrb),
        .rdata (w_core_rdata)
    );

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------

    // First read stage: valid, zero-override for out-of-range, bypass lanes.
    // Only updated on an accepted read so the result holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1       <= 1'b0;
            r_has_data <= 1'b0;
            r_byp_mask <= '0;
            r_byp_data <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_has_data <= w_b_in_range;
                r_byp_mask <= w_collide ? w_wea_bits : '0;
                r_byp_data <= dia;
            end
        end
    end

    // Core returns pre-write contents; write-first lanes are patched in here
    assign w_stage1_data = r_has_data ?
        DATA_WIDTH'(byte_merge(MERGE_W'(w_core_rdata), MERGE_W'(r_byp_data), MERGE_W'(r_byp_mask))) :
        '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_dob;
        logic                  r_dob_valid;

        // Extra output register: one more cycle of latency, holds between reads
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dob       <= '0;
                r_dob_valid <= 1'b0;
            end else begin
                r_dob_valid <= r_v1;
                if (r_v1) begin
                    r_dob <= w_stage1_data;
                end
            end
        end

        assign dob       = r_dob;
        assign dob_valid = r_dob_valid;
    end else begin : g_no_out_reg
        assign dob       = w_stage1_data;
        assign dob_valid = r_v1;
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_ram_be
// Description : Self-checking bench for dp_ram_be. Two instances share the
//               stimulus: A = 16 words, latency 1, write-first; B = 12 words,
//               latency 2, read-first (addresses 12..15 are out of range).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, enb, clr;
    logic [7:0]  wea;
    logic [3:0]  addra, addrb;
    logic [63:0] dia;
    logic [63:0] dob0, dob1;
    logic        val0, val1, busy0, busy1;

    always #5 clk = ~clk;

    dp_ram_be #(
        .RAM_DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8),
        .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .clr(clr),
        .dob(dob0), .dob_valid(val0), .init_busy(busy0)
    );

    dp_ram_be #(
        .RAM_DEPTH(12), .ADDR_WIDTH(4), .DATA_WIDTH(64), .BYTE_WIDTH(8),
        .OUT_REG(1), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .addrb(addrb), .clr(clr),
        .dob(dob1), .dob_valid(val1), .init_busy(busy1)
    );

    // Reference model state, one slot per instance
    int          m_depth [2] = '{16, 12};
    bit          m_byp   [2] = '{1'b1, 1'b0};
    bit          m_oreg  [2] = '{1'b0, 1'b1};
    logic [63:0] m_mem   [2][16];
    bit          m_busy  [2];
    int          m_cnt   [2];
    logic [63:0] m_dob   [2];
    bit          m_val   [2];
    bit          m_pv    [2];
    logic [63:0] m_pd    [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [63:0] tb_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                             input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b1;
            m_cnt[d]  = 0;
            m_dob[d]  = '0;
            m_val[d]  = 1'b0;
            m_pv[d]   = 1'b0;
            m_pd[d]   = '0;
        end
    endtask

    // Apply the rules for one rising edge using the inputs present at that edge
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit          acc;
            logic [63:0] rv;
            acc = 1'b0;
            rv  = '0;
            if (m_busy[d]) begin
                m_mem[d][m_cnt[d]] = '0;
                m_cnt[d]++;
                if (m_cnt[d] == m_depth[d]) begin
                    m_busy[d] = 1'b0;
                    m_cnt[d]  = 0;
                end
            end else begin
                if (enb) begin
                    acc = 1'b1;
                    if (int'(addrb) < m_depth[d]) begin
                        rv = m_mem[d][addrb];
                        if (m_byp[d] && ena && (addra == addrb)) rv = tb_merge(rv, dia, wea);
                    end
                end
                if (ena && (int'(addra) < m_depth[d]))
                    m_mem[d][addra] = tb_merge(m_mem[d][addra], dia, wea);
                if (clr) begin
                    m_busy[d] = 1'b1;
                    m_cnt[d]  = 0;
                end
            end
            if (m_oreg[d]) begin
                m_val[d] = m_pv[d];
                if (m_pv[d]) m_dob[d] = m_pd[d];
                m_pv[d] = acc;
                if (acc) m_pd[d] = rv;
            end else begin
                m_val[d] = acc;
                if (acc) m_dob[d] = rv;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dob_a",   dob0,         m_dob[0]);
        chk("valid_a", {63'd0, val0},  {63'd0, m_val[0]});
        chk("busy_a",  {63'd0, busy0}, {63'd0, m_busy[0]});
        chk("dob_b",   dob1,         m_dob[1]);
        chk("valid_b", {63'd0, val1},  {63'd0, m_val[1]});
        chk("busy_b",  {63'd0, busy1}, {63'd0, m_busy[1]});
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; clr = 1'b0; wea = '0;
    endtask

    task automatic cycle(input logic a_en, input logic [7:0] be, input logic [3:0] wa,
                         input logic [63:0] wd, input logic b_en, input logic [3:0] ra,
                         input logic c);
        ena = a_en; wea = be; addra = wa; dia = wd; enb = b_en; addrb = ra; clr = c;
        step();
        idle();
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) cycle(1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'(a), 1'b0);
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        addra = '0; addrb = '0; dia = '0;
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) m_mem[d][a] = '0;

        // Power-on reset, released mid-cycle; sweep must last the full depth
        #1;
        assert_reset();
        repeat (2) step();
        #3 rst = 1'b1;
        repeat (16) step();
        read_all();

        // Full write then low-half byte write to the same word
        cycle(1'b1, 8'hFF, 4'd3, 64'h1122334455667788, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 8'h0F, 4'd3, 64'hAAAAAAAABBBBBBBB, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd3, 1'b0);
        chk("partial_write_a", dob0, 64'h11223344BBBBBBBB);
        step();
        chk("partial_write_b", dob1, 64'h11223344BBBBBBBB);
        step();

        // Same-address collision on a zeroed word
        cycle(1'b1, 8'hFF, 4'd5, 64'hFF, 1'b1, 4'd5, 1'b0);
        chk("collide_write_first", dob0, 64'hFF);
        step();
        chk("collide_read_first", dob1, 64'h0);
        cycle(1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd5, 1'b0);
        step();
        chk("after_collide_b", dob1, 64'hFF);

        // Back-to-back reads produce a continuous valid stream
        for (int a = 0; a < 4; a++) begin
            ena = 1'b1; wea = 8'hFF; addra = 4'(8 + a); dia = {$urandom, $urandom};
            step();
        end
        idle();
        for (int a = 0; a < 4; a++) cycle(1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'(8 + a), 1'b0);
        repeat (3) step();

        // Randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            ena   = 1'($urandom_range(0, 1));
            wea   = 8'($urandom);
            addra = 4'($urandom);
            dia   = {$urandom, $urandom};
            enb   = 1'($urandom_range(0, 1));
            addrb = ($urandom_range(0, 1) == 0) ? addra : 4'($urandom);
            clr   = ($urandom_range(0, 49) == 0);
            step();
        end
        idle();
        repeat (20) step();

        // clr with a write, then repeated clr and port traffic mid-sweep
        cycle(1'b1, 8'hFF, 4'd2, 64'hDEADBEEFCAFEF00D, 1'b0, 4'd0, 1'b1);
        repeat (2) step();
        cycle(1'b1, 8'hFF, 4'd4, 64'h0123456789ABCDEF, 1'b1, 4'd4, 1'b1);
        repeat (16) step();
        read_all();

        // Reset asserted mid-sweep restarts the clear from word 0
        cycle(1'b1, 8'hFF, 4'd1, 64'h5A5A5A5A12345678, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd1, 1'b0);
        step();
        cycle(1'b1, 8'hFF, 4'd6, 64'h77, 1'b0, 4'd0, 1'b1);
        repeat (7) step();
        #2;
        assert_reset();
        chk("async_rst_dob_a", dob0, 64'h0);
        step();
        #3 rst = 1'b1;
        repeat (18) step();
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
